// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto one shared memory bus, with
// starvation guard for the instruction port and a bus-wait timeout.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 15
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        if_stall,
    output logic        mem_stall,
    output logic        bus_err
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUS_I, BUS_D, RESP} state_t;

    state_t          state;
    logic            we;
    logic [SW-1:0]   starve_cnt;
    logic [WW-1:0]   wait_cnt;
    logic            starved;
    logic            bus_done;
    logic            timed_out;

    assign starved   = (starve_cnt == SW'(STARVE_LIMIT));
    assign bus_done  = mem_ready || (wait_cnt == WW'(TIMEOUT - 1));
    assign timed_out = !mem_ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            we         <= 1'b0;
            starve_cnt <= '0;
            wait_cnt   <= '0;
            bus_err    <= 1'b0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (d_req && !(i_req && starved)) begin
                        state      <= BUS_D;
                        mem_addr   <= d_addr;
                        mem_wdata  <= d_wdata;
                        we         <= d_we;
                        // Only reached with starve_cnt below the limit when i_req is high.
                        starve_cnt <= i_req ? starve_cnt + 1'b1 : '0;
                    end else if (i_req) begin
                        state      <= BUS_I;
                        mem_addr   <= i_addr;
                        we         <= 1'b0;
                        starve_cnt <= '0;
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                BUS_I, BUS_D: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (bus_done) begin
                        state <= RESP;
                        // A ready in the final wait cycle wins over the timeout.
                        if (timed_out) bus_err <= 1'b1;
                        if (state == BUS_I) begin
                            i_rdata <= timed_out ? '0 : mem_rdata;
                            i_ack   <= 1'b1;
                        end else begin
                            d_rdata <= timed_out ? '0 : mem_rdata;
                            d_ack   <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_read  = (state == BUS_I) || ((state == BUS_D) && !we);
    assign mem_write = (state == BUS_D) && we;
    assign if_stall  = i_req & ~i_ack;
    assign mem_stall = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, starvation rotation, timeout,
// late ready, mid-transaction reset and dropped request.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_req, d_req, d_we, mem_ready;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic        i_ack, d_ack, mem_read, mem_write, if_stall, mem_stall, bus_err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(15)) dut (
        .clk(clk), .rstn(rstn),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .if_stall(if_stall), .mem_stall(mem_stall), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0; i_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        tick(); tick();
        check("rst_state", {i_ack, d_ack, mem_read, mem_write, bus_err}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_irdata", i_rdata, 32'd0);
        check("rst_drdata", d_rdata, 32'd0);
        rstn = 1'b1;

        // Instruction fetch, ready on 2nd bus cycle
        i_req = 1; i_addr = 32'h100;
        #1 check("f_c0_stall", if_stall, 1);
        check("f_c0_read", mem_read, 0);
        tick();
        check("f_c1_read", mem_read, 1);
        check("f_c1_addr", mem_addr, 32'h100);
        check("f_c1_stall", if_stall, 1);
        tick();
        mem_ready = 1; mem_rdata = 32'h2402000A;
        check("f_c2_ack", i_ack, 0);
        check("f_c2_stall", if_stall, 1);
        tick();
        mem_ready = 0;
        check("f_c3_ack", i_ack, 1);
        check("f_c3_rdata", i_rdata, 32'h2402000A);
        check("f_c3_stall", if_stall, 0);
        check("f_c3_read", mem_read, 0);
        i_req = 0;
        tick();
        check("f_c4_ack", i_ack, 0);

        // Both ports requesting: 4 data grants then 1 instruction grant, repeating
        i_req = 1; i_addr = 32'h104;
        d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
        mem_ready = 1; mem_rdata = 32'h12345678;
        for (int g = 0; g < 10; g++) begin
            logic is_i;
            is_i = ((g % 5) == 4);
            tick();
            check($sformatf("s%0d_read", g), mem_read, is_i);
            check($sformatf("s%0d_write", g), mem_write, !is_i);
            check($sformatf("s%0d_addr", g), mem_addr, is_i ? 32'h104 : 32'h200);
            if (!is_i) check($sformatf("s%0d_wdata", g), mem_wdata, 32'hDEADBEEF);
            tick();
            check($sformatf("s%0d_iack", g), i_ack, is_i);
            check($sformatf("s%0d_dack", g), d_ack, !is_i);
            check($sformatf("s%0d_strb", g), {mem_read, mem_write}, 0);
            tick();
        end
        i_req = 0; d_req = 0; mem_ready = 0;
        tick();

        // Data read with no ready: aborts after 15 wait cycles
        d_req = 1; d_we = 0; d_addr = 32'h300; mem_rdata = 32'hAAAA5555;
        tick();
        check("t_bus1_read", mem_read, 1);
        for (int c = 2; c <= 15; c++) tick();
        check("t_bus15_read", mem_read, 1);
        check("t_bus15_ack", d_ack, 0);
        tick();
        check("t_ack", d_ack, 1);
        check("t_rdata", d_rdata, 32'd0);
        check("t_err", bus_err, 1);
        check("t_read_off", mem_read, 0);
        d_req = 0;
        tick();
        check("t_ack_once", d_ack, 0);
        tick();
        check("t_err_held", bus_err, 1);
        rstn = 0;
        tick();
        check("t_err_clr", bus_err, 0);
        rstn = 1;

        // Ready in 15th wait cycle: success, no error
        d_req = 1; d_we = 0; d_addr = 32'h304;
        tick();
        for (int c = 2; c <= 15; c++) tick();
        check("l_bus15_ack", d_ack, 0);
        mem_ready = 1; mem_rdata = 32'h0BADF00D;
        tick();
        mem_ready = 0;
        check("l_ack", d_ack, 1);
        check("l_rdata", d_rdata, 32'h0BADF00D);
        check("l_err", bus_err, 0);
        d_req = 0;
        tick();

        // Reset in 2nd BUS_D cycle abandons the write
        d_req = 1; d_we = 1; d_addr = 32'h208; d_wdata = 32'h11;
        tick();
        check("r_bus1_write", mem_write, 1);
        tick();
        rstn = 0;
        tick();
        check("r_ack", d_ack, 0);
        check("r_strb", {mem_read, mem_write}, 0);
        check("r_addr", mem_addr, 32'd0);
        check("r_wdata", mem_wdata, 32'd0);
        check("r_drdata", d_rdata, 32'd0);
        rstn = 1; d_req = 0;
        tick();
        check("r_idle_ack", d_ack, 0);
        d_req = 1; d_addr = 32'h20C; d_wdata = 32'hCAFE; mem_ready = 1;
        tick();
        check("r_new_write", mem_write, 1);
        check("r_new_addr", mem_addr, 32'h20C);
        check("r_new_wdata", mem_wdata, 32'hCAFE);
        tick();
        mem_ready = 0;
        check("r_new_ack", d_ack, 1);
        d_req = 0;
        tick();

        // Request dropped after grant still completes
        d_req = 1; d_we = 1; d_addr = 32'h210; d_wdata = 32'h55AA;
        tick();
        d_req = 0;
        #1 check("d_bus1_write", mem_write, 1);
        check("d_stall", mem_stall, 0);
        tick();
        check("d_bus2_write", mem_write, 1);
        check("d_bus2_ack", d_ack, 0);
        mem_ready = 1;
        tick();
        mem_ready = 0;
        check("d_ack", d_ack, 1);
        tick();
        check("d_ack_once", d_ack, 0);
        tick();
        check("d_ack_idle", d_ack, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    always @(negedge clk) begin
        if (rstn && mem_read && mem_write) begin
            n_checks++;
            n_fail++;
            $display("FAIL strobe_excl: read=%b write=%b required not both 1", mem_read, mem_write);
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4: the maximum number of consecutive data grants allowed while an instruction request waits.
REQ-002 The block SHALL have parameter TIMEOUT, default 15: the maximum number of bus wait cycles before a transaction is aborted.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rstn  in  1  reset, synchronous, active-low.
REQ-005 i_req  in  1  instruction-fetch read request; held high until i_ack.
REQ-006 i_addr  in  32  instruction fetch address.
REQ-007 i_rdata  out  32  fetched instruction; valid while i_ack=1.
REQ-008 i_ack  out  1  one-cycle completion pulse for the instruction port.
REQ-009 d_req, d_we  in  1 each  data request; d_we=1 selects write, d_we=0 selects read; held until d_ack.
REQ-010 d_addr, d_wdata  in  32 each  data address and write data.
REQ-011 d_rdata  out  32  load data; valid while d_ack=1.
REQ-012 d_ack  out  1  one-cycle completion pulse for the data port.
REQ-013 mem_addr, mem_wdata  out  32 each  shared memory bus address and write data.
REQ-014 mem_read, mem_write  out  1 each  bus command strobes; never both 1.
REQ-015 mem_rdata  in  32; mem_ready  in  1  memory read data and completion.
REQ-016 if_stall, mem_stall  out  1 each  pipeline stall requests for the IF and MEM stages.
REQ-017 bus_err  out  1  sticky timeout flag.

Function
REQ-018 FSM states SHALL be IDLE, BUS_I, BUS_D and RESP.
- IDLE: no request -> stay in IDLE.
- IDLE: request present -> BUS_I or BUS_D.
- BUS_x: mem_ready=1 or timeout -> RESP.
- RESP -> IDLE, unconditionally.
REQ-019 Arbitration in IDLE SHALL follow these rules:
- d_req only -> BUS_D.
- i_req only -> BUS_I.
- Both requests -> BUS_D, unless starve_cnt==STARVE_LIMIT, in which case -> BUS_I.
REQ-020 starve_cnt SHALL count as follows:
- +1 on each BUS_D grant while i_req=1.
- Cleared on a BUS_I grant or whenever i_req=0 in IDLE.
- Saturates at STARVE_LIMIT.
REQ-021 On grant, address, write data and we SHALL be registered, and the bus outputs SHALL be driven from these registers for the whole BUS_x state.
REQ-022 mem_read SHALL be 1 in BUS_I and in BUS_D with we=0; mem_write SHALL be 1 in BUS_D with we=1; both SHALL be 0 in IDLE and RESP.
REQ-023 On the mem_ready cycle, mem_rdata SHALL be captured into the granted port's rdata register, and that port's ack SHALL be 1 for exactly the following RESP cycle.
REQ-024 Latency SHALL be one cycle from request to first bus cycle; with mem_ready in bus cycle k (k>=1), ack SHALL be asserted at cycle k+1 after grant.
REQ-025 Requests SHALL be ignored in BUS_x and RESP; a request still high in RESP SHALL be arbitrated in the next IDLE cycle.
REQ-026 A request dropped mid-transaction SHALL NOT abort the transaction; the transaction completes and ack still pulses.
REQ-027 wait_cnt SHALL count BUS_x cycles without mem_ready; when it reaches TIMEOUT, the transaction SHALL abort to RESP.
REQ-028 On timeout, rdata SHALL be 0, ack SHALL pulse, and bus_err SHALL be set to 1 and held until reset.
REQ-029 mem_ready in the same cycle as the timeout SHALL be treated as success, with no error.
REQ-030 if_stall SHALL equal i_req & ~i_ack, and mem_stall SHALL equal d_req & ~d_ack, combinationally.
REQ-031 mem_ready received in IDLE or RESP SHALL be ignored.

Reset
REQ-032 While rstn=0 at a clock edge, the block SHALL enter IDLE, and the following SHALL be 0:
- starve_cnt, wait_cnt, bus_err
- i_ack, d_ack, mem_read, mem_write
- mem_addr, mem_wdata, i_rdata, d_rdata
REQ-033 Reset asserted mid-transaction SHALL abandon the transaction with no ack; bus strobes SHALL be 0 from the first post-reset cycle.

Verification
REQ-034 i_req, i_addr=0x100; mem_ready on the 2nd bus cycle with mem_rdata=0x2402000A -> mem_read=1 at 0x100, i_ack at cycle 3 with i_rdata=0x2402000A, if_stall=1 in cycles 0-2.
REQ-035 i_req and d_req (d_we=1, 0x200, 0xDEADBEEF) both held every cycle, memory ready in 1 cycle -> STARVE_LIMIT(4) data grants, then one instruction grant, repeating; mem_write is never asserted together with mem_read.
REQ-036 d_req read with mem_ready never asserted -> abort after 15 wait cycles, d_ack=1 with d_rdata=0, bus_err=1 and held.
REQ-037 mem_ready in the 15th wait cycle -> normal completion, bus_err=0.
REQ-038 rstn=0 in the 2nd cycle of BUS_D -> no d_ack, all outputs 0, next request serviced normally.
REQ-039 d_req dropped after grant -> the write still completes and d_ack pulses once.
